// File: rtl/stopwatch_time_counter_pkg.sv
// Shared types and helpers for the stopwatch time base: BCD time layout,
// digit limits and a reference single-step BCD increment.
package stopwatch_pkg;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
        logic [3:0] cs_tens;
        logic [3:0] cs_ones;
    } bcd_time_t;

    // Returns {carry_out, next_time}; carry_out is set on 59:59.99 -> 00:00.00.
    function automatic logic [24:0] bcd_time_inc(input bcd_time_t t);
        bcd_time_t n;
        logic      c;
        n = t;
        c = 1'b1;
        if (t.cs_ones == DIGIT_MAX) n.cs_ones = 4'd0;
        else begin n.cs_ones = t.cs_ones + 4'd1; c = 1'b0; end
        if (c) begin
            if (t.cs_tens == DIGIT_MAX) n.cs_tens = 4'd0;
            else begin n.cs_tens = t.cs_tens + 4'd1; c = 1'b0; end
        end
        if (c) begin
            if (t.sec_ones == DIGIT_MAX) n.sec_ones = 4'd0;
            else begin n.sec_ones = t.sec_ones + 4'd1; c = 1'b0; end
        end
        if (c) begin
            if (t.sec_tens == SEC_TENS_MAX) n.sec_tens = 4'd0;
            else begin n.sec_tens = t.sec_tens + 4'd1; c = 1'b0; end
        end
        if (c) begin
            if (t.min_ones == DIGIT_MAX) n.min_ones = 4'd0;
            else begin n.min_ones = t.min_ones + 4'd1; c = 1'b0; end
        end
        if (c) begin
            if (t.min_tens == MIN_TENS_MAX) n.min_tens = 4'd0;
            else begin n.min_tens = t.min_tens + 4'd1; c = 1'b0; end
        end
        return {c, n};
    endfunction

endpackage

// File: rtl/stopwatch_time_counter_digit.sv
// One BCD digit of the time chain; wraps MAX -> 0 and reports carry
// combinationally so all digits of the chain advance on the same edge.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] value,
    output logic       carry
);

    logic [3:0] r_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_value <= 4'd0;
        else if (clr)
            r_value <= 4'd0;
        else if (inc)
            r_value <= (r_value == MAX) ? 4'd0 : r_value + 4'd1;
    end

    assign value = r_value;
    assign carry = inc && (r_value == MAX);

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch time base: prescales clk to centisecond ticks, accumulates
// MM:SS.cc in BCD, and offers lap-hold freezing plus a sticky wrap flag.
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100000000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       running,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] cs_tens,
    output logic [3:0] cs_ones,
    output logic       tick,
    output logic       lap_active,
    output logic       wrapped
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV < 2) ? 1 : $clog2(DIV);

    generate
        if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
            $error("stopwatch_time_counter: CLK_HZ/TICK_HZ must be an integer >= 2");
        end
    endgenerate

    logic [PW-1:0] r_presc;
    logic          r_tick;
    logic          r_lap_active;
    logic          r_wrapped;
    bcd_time_t     r_snap;

    logic          w_tick_now;
    logic [5:0]    w_carry;
    logic [3:0]    w_cs_ones, w_cs_tens, w_sec_ones, w_sec_tens, w_min_ones, w_min_tens;
    bcd_time_t     w_live;
    bcd_time_t     w_disp;

    // Prescaler only advances while running, so a pause keeps the sub-tick phase.
    assign w_tick_now = running && (r_presc == PW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_presc <= '0;
        else if (clear || w_tick_now)
            r_presc <= '0;
        else if (running)
            r_presc <= r_presc + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick    <= 1'b0;
            r_wrapped <= 1'b0;
        end else if (clear) begin
            r_tick    <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            r_tick <= w_tick_now;
            if (w_carry[5])
                r_wrapped <= 1'b1;
        end
    end

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_cs_ones (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_tick_now),
        .value(w_cs_ones), .carry(w_carry[0])
    );
    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_cs_tens (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_carry[0]),
        .value(w_cs_tens), .carry(w_carry[1])
    );
    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_sec_ones (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_carry[1]),
        .value(w_sec_ones), .carry(w_carry[2])
    );
    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_carry[2]),
        .value(w_sec_tens), .carry(w_carry[3])
    );
    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_min_ones (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_carry[3]),
        .value(w_min_ones), .carry(w_carry[4])
    );
    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_carry[4]),
        .value(w_min_tens), .carry(w_carry[5])
    );

    assign w_live = '{min_tens: w_min_tens, min_ones: w_min_ones,
                      sec_tens: w_sec_tens, sec_ones: w_sec_ones,
                      cs_tens:  w_cs_tens,  cs_ones:  w_cs_ones};

    // Snapshot takes the pre-increment live value when lap and tick coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lap_active <= 1'b0;
            r_snap       <= '0;
        end else if (clear) begin
            r_lap_active <= 1'b0;
        end else if (lap) begin
            if (!r_lap_active) begin
                r_snap       <= w_live;
                r_lap_active <= 1'b1;
            end else begin
                r_lap_active <= 1'b0;
            end
        end
    end

    assign w_disp = r_lap_active ? r_snap : w_live;

    assign {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones} = w_disp;
    assign tick       = r_tick;
    assign lap_active = r_lap_active;
    assign wrapped    = r_wrapped;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter at DIV=10: per-cycle scoreboard against an
// integer-centisecond model, plus table segments and hand-written corner cases.
module tb_stopwatch_time_counter;

    localparam int DIV    = 10;
    localparam int WRAPCS = 360000;

    logic clk = 1'b0;
    logic rst, running, clear, lap;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones;
    logic tick, lap_active, wrapped;

    stopwatch_time_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk(clk), .rst(rst), .running(running), .clear(clear), .lap(lap),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .cs_tens(cs_tens), .cs_ones(cs_ones),
        .tick(tick), .lap_active(lap_active), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    logic [26:0] w_obs;
    assign w_obs = {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones,
                    tick, lap_active, wrapped};

    int total = 0;
    int bad   = 0;

    int m_live, m_snap, m_presc;
    bit m_tick, m_lapa, m_wrap;

    logic [26:0] sb_q[$];
    logic [23:0] pl_bcd;

    typedef struct {
        bit          run;
        bit          clr;
        bit          lp;
        int          n;
        logic [23:0] disp;
        bit          tk;
        bit          la;
        bit          wr;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [23:0] to_bcd(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [26:0] model_out();
        return {to_bcd(m_lapa ? m_snap : m_live), m_tick, m_lapa, m_wrap};
    endfunction

    task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got disp=%h tick/lap/wrap=%b, want disp=%h tick/lap/wrap=%b",
                     name, act[26:3], act[2:0], exp[26:3], exp[2:0]);
        end
    endtask

    task automatic model_reset();
        m_live = 0; m_snap = 0; m_presc = 0;
        m_tick = 0; m_lapa = 0; m_wrap = 0;
    endtask

    task automatic step(input bit r, input bit c, input bit l);
        bit t;
        logic [26:0] exp;
        @(negedge clk);
        running = r; clear = c; lap = l;
        if (c) begin
            m_live = 0; m_presc = 0; m_wrap = 0; m_lapa = 0; m_tick = 0;
        end else begin
            t = r && (m_presc == DIV - 1);
            if (l) begin
                if (!m_lapa) begin m_snap = m_live; m_lapa = 1; end
                else m_lapa = 0;
            end
            if (t) begin
                m_presc = 0;
                m_live++;
                if (m_live == WRAPCS) begin m_live = 0; m_wrap = 1; end
            end else if (r) begin
                m_presc++;
            end
            m_tick = t;
        end
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        check("cycle", w_obs, exp);
    endtask

    task automatic run_n(input bit r, input bit c, input bit l, input int n);
        for (int i = 0; i < n; i++) step(r, c, l);
    endtask

    // Loads the live digits between edges; the digit flops keep the value after release.
    task automatic preload(input int cs);
        pl_bcd = to_bcd(cs);
        force dut.u_min_tens.r_value = pl_bcd[23:20];
        force dut.u_min_ones.r_value = pl_bcd[19:16];
        force dut.u_sec_tens.r_value = pl_bcd[15:12];
        force dut.u_sec_ones.r_value = pl_bcd[11:8];
        force dut.u_cs_tens.r_value  = pl_bcd[7:4];
        force dut.u_cs_ones.r_value  = pl_bcd[3:0];
        #1;
        release dut.u_min_tens.r_value;
        release dut.u_min_ones.r_value;
        release dut.u_sec_tens.r_value;
        release dut.u_sec_ones.r_value;
        release dut.u_cs_tens.r_value;
        release dut.u_cs_ones.r_value;
        m_live = cs;
    endtask

    initial begin
        vecs[0] = '{1, 0, 0,  10, 24'h000001, 1, 0, 0};
        vecs[1] = '{0, 1, 0,   1, 24'h000000, 0, 0, 0};
        vecs[2] = '{1, 0, 0, 995, 24'h000099, 0, 0, 0};
        vecs[3] = '{1, 0, 0,   5, 24'h000100, 1, 0, 0};
        vecs[4] = '{0, 1, 0,   1, 24'h000000, 0, 0, 0};
        vecs[5] = '{1, 0, 0,   3, 24'h000000, 0, 0, 0};
        vecs[6] = '{0, 0, 0,  50, 24'h000000, 0, 0, 0};
        vecs[7] = '{1, 0, 0,   7, 24'h000001, 1, 0, 0};
        vecs[8] = '{0, 1, 0,   1, 24'h000000, 0, 0, 0};

        rst = 1'b1; running = 1'b0; clear = 1'b0; lap = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset", w_obs, 27'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_n(vecs[i].run, vecs[i].clr, vecs[i].lp, vecs[i].n);
            check($sformatf("seg%0d", i), w_obs,
                  {vecs[i].disp, vecs[i].tk, vecs[i].la, vecs[i].wr});
        end

        // Rollover and sticky wrapped
        preload(359994);
        run_n(1, 0, 0, 50);
        check("pre_wrap", w_obs, {24'h595999, 3'b100});
        run_n(1, 0, 0, 10);
        check("wrap", w_obs, {24'h000000, 3'b101});
        run_n(1, 0, 0, 50);
        check("wrap_sticky", w_obs, {24'h000005, 3'b101});
        step(0, 1, 0);
        check("wrap_clear", w_obs, {24'h000000, 3'b000});

        // Lap on a tick edge at 00:12.34
        preload(1234);
        run_n(1, 0, 0, 9);
        step(1, 0, 1);
        check("lap_freeze", w_obs, {24'h001234, 3'b110});
        run_n(1, 0, 0, 650);
        check("lap_hold", w_obs, {24'h001234, 3'b110});
        step(1, 0, 1);
        check("lap_release", w_obs, {24'h001300, 3'b000});

        // clear + lap on a tick edge at 00:05.00
        step(0, 1, 0);
        preload(500);
        run_n(1, 0, 0, 9);
        step(1, 1, 1);
        check("clr_lap", w_obs, {24'h000000, 3'b000});
        run_n(1, 0, 0, 9);
        check("clr_restart9", w_obs, {24'h000000, 3'b000});
        step(1, 0, 0);
        check("clr_restart10", w_obs, {24'h000001, 3'b100});

        // Asynchronous reset mid-count
        run_n(1, 0, 0, 25);
        @(negedge clk);
        running = 1'b0; clear = 1'b0; lap = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_async", w_obs, 27'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        run_n(1, 0, 0, 10);
        check("post_rst", w_obs, {24'h000001, 3'b100});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
